// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t ADJ_THRESH = 4'd5;
    localparam bcd_digit_t ADJ_ADD    = 4'd3;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble digit correction: +3 when the digit is >= 5
//
// Ports:
//   digit_in   BCD digit before the shift
//   digit_out  digit_in + 3 if digit_in >= 5, else digit_in
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    // Only legal digits 0..9 matter; out-of-range values (overflowed
    // scratch) simply wrap and are flagged by the top-level ovf bit.
    assign digit_out = (digit_in >= ADJ_THRESH) ? digit_in + ADJ_ADD : digit_in;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with valid/ready handshakes
//
// Optional feature: define BIN2BCD_SIGNED_EN to treat in_data as two's
// complement; the magnitude is converted and out_sign carries the sign.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready high only in IDLE
//   in_data              binary value (BIN_W bits)
//   out_valid/out_ready  result handshake; result held while out_valid && !out_ready
//   out_bcd              DIGITS packed BCD digits, ones digit at [3:0]
//   out_ovf              value >= 10**DIGITS, out_bcd not meaningful
//   out_sign             (BIN2BCD_SIGNED_EN only) 1 = negative input
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DIGITS*4-1:0]     out_bcd,
    output logic                    out_ovf
`ifdef BIN2BCD_SIGNED_EN
    ,
    output logic                    out_sign
`endif
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [BCD_W-1:0]   adj;
    logic [BIN_W-1:0]   load_mag;

`ifdef BIN2BCD_SIGNED_EN
    logic               sign_q, sign_d;
    logic               load_sign;

    // Negating the most-negative value yields 2^(BIN_W-1) when read as
    // unsigned, which is exactly the magnitude we want.
    assign load_sign = in_data[BIN_W-1];
    assign load_mag  = load_sign ? (~in_data + BIN_W'(1)) : in_data;
`else
    assign load_mag  = in_data;
`endif

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
        sign_d  = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = load_mag;
                    bcd_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
`ifdef BIN2BCD_SIGNED_EN
                    sign_d  = load_sign;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Shift {adjusted scratch, bin} left by one; the bit leaving
                // the top digit is a carry into a digit we do not have.
                bcd_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
                bin_d = {bin_q[BIN_W-2:0], 1'b0};
                if (adj[BCD_W-1]) begin
                    ovf_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_bcd   = bcd_q;
    assign out_ovf   = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    assign out_sign  = sign_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq (3-digit and 2-digit instances)
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;

    logic        in_ready3, out_valid3, out_ovf3;
    logic [11:0] out_bcd3;
    logic        in_ready2, out_valid2, out_ovf2;
    logic [7:0]  out_bcd2;
`ifdef BIN2BCD_SIGNED_EN
    logic        out_sign3, out_sign2;
`endif

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        logic        sign;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];
    exp_t e3, e2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .in_data   (in_data),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .out_bcd   (out_bcd3),
        .out_ovf   (out_ovf3)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .out_sign  (out_sign3)
`endif
    );

    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready2),
        .in_data   (in_data),
        .out_valid (out_valid2),
        .out_ready (out_ready),
        .out_bcd   (out_bcd2),
        .out_ovf   (out_ovf2)
`ifdef BIN2BCD_SIGNED_EN
        ,
        .out_sign  (out_sign2)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: decimal digits by division, overflow by magnitude compare.
    function automatic exp_t model(input logic [7:0] v, input int digits);
        exp_t r;
        int   mag;
        int   p;
        mag    = int'(v);
        r.sign = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
        if (v >= 8'd128) begin
            r.sign = 1'b1;
            mag    = 256 - int'(v);
        end
`endif
        p     = 1;
        r.bcd = '0;
        for (int i = 0; i < digits; i++) begin
            r.bcd[4*i +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        r.ovf = (mag >= p);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid3 && out_ready) begin
            if (q3.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out3: got bcd %0h with empty queue", out_bcd3);
            end else begin
                e3 = q3.pop_front();
                chk("ovf3", 32'(out_ovf3), 32'(e3.ovf));
                if (!e3.ovf) chk("bcd3", 32'(out_bcd3), 32'(e3.bcd));
`ifdef BIN2BCD_SIGNED_EN
                chk("sign3", 32'(out_sign3), 32'(e3.sign));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid2 && out_ready) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_out2: got bcd %0h with empty queue", out_bcd2);
            end else begin
                e2 = q2.pop_front();
                chk("ovf2", 32'(out_ovf2), 32'(e2.ovf));
                if (!e2.ovf) chk("bcd2", 32'(out_bcd2), 32'(e2.bcd[7:0]));
`ifdef BIN2BCD_SIGNED_EN
                chk("sign2", 32'(out_sign2), 32'(e2.sign));
`endif
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int n = 0;
        while (!(in_ready3 && in_ready2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready %0b/%0b expected 1", in_ready3, in_ready2);
        end
        in_valid = 1'b1;
        in_data  = v;
        q3.push_back(model(v, 3));
        q2.push_back(model(v, 2));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q3.size() != 0 || q2.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d/%0d results pending expected 0", q3.size(), q2.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid3), 32'd0);
        chk("rst_out_bcd",   32'(out_bcd3),   32'd0);
        chk("rst_out_ovf",   32'(out_ovf3),   32'd0);
        chk("rst_in_ready",  32'(in_ready3),  32'd1);
        chk("rst_in_ready2", 32'(in_ready2),  32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // First conversion: latency from accept edge to out_valid
        send(8'd0);
        n = 0;
        while (!out_valid3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'd8);
        drain();

        send(8'd255);
        send(8'd99);
        send(8'd100);
        send(8'hF6);
        send(8'h80);
        drain();

        // Backpressure: result held, input ignored while busy
        out_ready = 1'b0;
        send(8'd200);
        n = 0;
        while (!out_valid3 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                in_valid = 1'b1;
                in_data  = 8'd7;
            end else begin
                in_valid = 1'b0;
            end
            chk("bp_out_valid", 32'(out_valid3), 32'd1);
            chk("bp_bcd_hold",  32'(out_bcd3),   32'(q3[0].bcd));
            chk("bp_in_ready",  32'(in_ready3),  32'd0);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_in_ready",  32'(in_ready3),  32'd1);
        chk("bp_release_out_valid", 32'(out_valid3), 32'd0);
        chk("bp_release_popped",    32'(q3.size()),  32'd0);

        for (int v = 0; v < 256; v++) begin
            send(8'(v));
        end
        drain();

        for (int i = 0; i < 60; i++) begin
            send(8'($urandom_range(0, 255)));
        end
        drain();

        // Reset in the middle of a conversion
        send(8'd123);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid3), 32'd0);
        chk("midrst_out_bcd",   32'(out_bcd3),   32'd0);
        chk("midrst_in_ready",  32'(in_ready3),  32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        q3.delete();
        q2.delete();
        @(posedge clk); #1;
        send(8'd42);
        drain();

        repeat (20) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
